// File: rtl/hazard_fsm.sv
// hazard_fsm: load-use, branch-flush and multi-cycle MDU stall control for a 3-step pipeline
module hazard_fsm #(
  parameter int MDU_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        ex_mdu_start,
  output logic        load_hazard_signal,
  output logic        stall_from_step3,
  output logic        bubble_step2,
  output logic        hold_step3,
  output logic        mdu_done,
  output logic [15:0] stall_cycles
);
  typedef enum logic {RUN, MDU_WAIT} state_t;
  localparam logic [7:0] CNT_INIT = 8'(MDU_CYCLES - 2);
  state_t state, state_n, cur;
  logic [7:0] cnt, cnt_n;
  logic lu, br, mdu;
  assign br  = ex_valid & ex_branch_taken;
  assign mdu = ex_valid & ex_mdu_start;
  assign lu  = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
               ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  // next-state and control decode; reset forces RUN decoding so an aborted MDU op never pulses done
  always_comb begin
    cur = reset ? RUN : state;
    state_n = cur;
    cnt_n = cnt;
    load_hazard_signal = 1'b0;
    stall_from_step3 = 1'b0;
    bubble_step2 = 1'b0;
    hold_step3 = 1'b0;
    mdu_done = 1'b0;
    if (cur == RUN) begin
      cnt_n = '0;
      if (br) begin
        stall_from_step3 = 1'b1;
        bubble_step2 = 1'b1;
      end else if (mdu) begin
        load_hazard_signal = 1'b1;
        hold_step3 = 1'b1;
        state_n = MDU_WAIT;
        cnt_n = CNT_INIT;
      end else if (lu) begin
        load_hazard_signal = 1'b1;
        bubble_step2 = 1'b1;
      end
    end else if (cnt != 8'd0) begin
      load_hazard_signal = 1'b1;
      hold_step3 = 1'b1;
      cnt_n = cnt - 8'd1;
    end else begin
      mdu_done = 1'b1;
      state_n = RUN;
    end
  end
  // state, MDU countdown and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (load_hazard_signal && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
  end
endmodule

// File: doc/hazard_fsm.md
HAZARD_FSM -- requirements
Module: hazard_fsm

Interface
REQ-001 Parameter MDU_CYCLES, default 4, legal range 2..255: total cycles a multiply/divide instruction occupies step3, including the cycle it leaves.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_rs, id_rt  input  5 each  source register numbers of the instruction in step2.
REQ-005 id_uses_rs, id_uses_rt  input  1 each  step2 instruction actually reads rs / rt.
REQ-006 ex_valid  input  1  step3 holds a real (non-bubble) instruction.
REQ-007 ex_rd  input  5  destination register of the step3 instruction.
REQ-008 ex_mem_read  input  1  step3 instruction is a load.
REQ-009 ex_branch_taken  input  1  step3 resolved a taken branch/jump this cycle.
REQ-010 ex_mdu_start  input  1  step3 holds a multiply/divide instruction.
REQ-011 load_hazard_signal  output  1  freeze PC and step1 register (feeds fsm_step1).
REQ-012 stall_from_step3  output  1  flush step1 register (feeds fsm_step1).
REQ-013 bubble_step2  output  1  load a bubble into the step2->step3 register.
REQ-014 hold_step3  output  1  hold the step3 register contents.
REQ-015 mdu_done  output  1  one-cycle pulse: MDU result valid, instruction leaves step3.
REQ-016 stall_cycles  output  16  saturating count of cycles with load_hazard_signal=1.

Function
REQ-017 States: RUN, MDU_WAIT; 8-bit down-counter cnt used only in MDU_WAIT.
REQ-018 Load-use condition LU = ex_valid & ex_mem_read & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)); combinational, same cycle.
REQ-019 Event priority in RUN: ex_branch_taken > ex_mdu_start > LU; lower-priority events that cycle are ignored.
REQ-020 RUN, ex_valid & ex_branch_taken: stall_from_step3=1, bubble_step2=1, load_hazard_signal=0, hold_step3=0; stay RUN.
REQ-021 RUN, ex_valid & ex_mdu_start (no branch): load_hazard_signal=1, hold_step3=1, bubble_step2=0; next state MDU_WAIT, cnt <= MDU_CYCLES-2.
REQ-022 MDU_WAIT, cnt!=0: load_hazard_signal=1, hold_step3=1, all other flags 0; cnt decrements by 1; ex_* inputs ignored.
REQ-023 MDU_WAIT, cnt==0: all freeze/flush outputs 0, mdu_done=1; next state RUN; ex_mdu_start ignored this cycle.
REQ-024 Freeze length per MDU op = MDU_CYCLES-1 cycles; mdu_done asserted exactly once per op.
REQ-025 RUN, LU (no branch, no MDU): load_hazard_signal=1, bubble_step2=1, stall_from_step3=0, hold_step3=0; stay RUN (one bubble; load then leaves step3, LU clears).
REQ-026 RUN, no event: all control outputs 0.
REQ-027 ex_valid=0: ex_branch_taken, ex_mdu_start, LU all treated as 0.
REQ-028 Register 0 never causes a load-use stall.
REQ-029 stall_cycles increments on every clock edge where load_hazard_signal=1; holds at 16'hFFFF, no wrap.
REQ-030 All control outputs are combinational from state, cnt and inputs; no X propagation from unused inputs.

Reset
REQ-031 reset=1 at clock edge: state <= RUN, cnt <= 0, stall_cycles <= 0; takes priority over every event.
REQ-032 While reset=1, outputs follow RUN decoding of current inputs; reset mid-MDU_WAIT aborts the op with no mdu_done.

Verification
REQ-033 Load-use: ex_valid=1, ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> same cycle load_hazard_signal=1, bubble_step2=1; next cycle (ex_valid=0) all 0; stall_cycles=1.
REQ-034 r0 / unused operand: ex_rd=0=id_rs, or ex_rd=7=id_rt with id_uses_rt=0 -> no stall.
REQ-035 MDU, MDU_CYCLES=4: ex_mdu_start held -> hold_step3=load_hazard_signal=1 for 3 cycles, mdu_done=1 in 4th cycle only, back to RUN; stall_cycles=3.
REQ-036 Branch priority: ex_branch_taken=1 with LU also true -> stall_from_step3=1, bubble_step2=1, load_hazard_signal=0.
REQ-037 Reset mid-op: reset in 2nd MDU_WAIT cycle -> next cycle RUN, no mdu_done, stall_cycles=0.
REQ-038 Saturation: force 65540 load-use cycles -> stall_cycles reads 16'hFFFF and stays there.
